dds_oscillator: RTL

- Numerically controlled oscillator that produces the raw unsigned sample stream consumed by the synthesizer's digital filter stage.
- A phase accumulator advances by a tuning word once per sample tick. The tick comes from an internal clock divider.
- Generates saw, square (variable duty), triangle or LFSR noise. Output is offset binary with midscale = silence.
- Emits a one-cycle sample_valid strobe with each new sample.

---
 rtl/dds_oscillator.sv | 90 +++++++++
 1 files changed

// File: rtl/dds_oscillator.sv
// Numerically controlled oscillator: phase accumulator stepped by an internal
// clock divider, producing saw/square/triangle/noise as offset-binary samples.
module dds_oscillator #(
    parameter int unsigned n     = 12,
    parameter int unsigned ACC_W = 24,
    parameter int unsigned DIV   = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             enable,
    input  logic             sync,
    input  logic [ACC_W-1:0] tuning_word,
    input  logic [1:0]       wave_sel,
    input  logic [n-1:0]     duty,
    output logic [n-1:0]     sample_out,
    output logic             sample_valid
);

    localparam int unsigned CNT_W   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned LFSR_W  = 16;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;
    localparam logic [n-1:0] MIDSCALE = {1'b1, {(n-1){1'b0}}};
    localparam logic [1:0] WAVE_SAW      = 2'd0;
    localparam logic [1:0] WAVE_SQUARE   = 2'd1;
    localparam logic [1:0] WAVE_TRIANGLE = 2'd2;

    logic [CNT_W-1:0]  tick_cnt;
    logic [ACC_W-1:0]  phase;
    logic [LFSR_W-1:0] lfsr;
    logic              pending;

    logic              tick_c;
    logic [LFSR_W-1:0] lfsr_next_c;
    logic [n-1:0]      p_c;
    logic [n-1:0]      tri_c;
    logic [n-1:0]      wave_c;

    assign tick_c      = (tick_cnt == CNT_W'(DIV - 1));
    assign lfsr_next_c = (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : LFSR_W'(0));
    assign p_c         = phase[ACC_W-1 -: n];
    assign tri_c       = {p_c[n-2:0], 1'b0};

    // Waveform shaping from the phase already advanced on the tick edge
    always_comb begin
        wave_c = p_c;
        case (wave_sel)
            WAVE_SAW:      wave_c = p_c;
            WAVE_SQUARE:   wave_c = (p_c < duty) ? {n{1'b1}} : {n{1'b0}};
            WAVE_TRIANGLE: wave_c = p_c[n-1] ? ~tri_c : tri_c;
            default:       wave_c = lfsr[LFSR_W-1 -: n];
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            tick_cnt     <= '0;
            phase        <= '0;
            lfsr         <= LFSR_SEED;
            pending      <= 1'b0;
            sample_out   <= MIDSCALE;
            sample_valid <= 1'b0;
        end else begin
            tick_cnt <= tick_c ? '0 : tick_cnt + CNT_W'(1);

            // Hard sync overrides the tick increment
            if (sync) begin
                phase <= '0;
            end else if (tick_c && enable) begin
                phase <= phase + tuning_word;
            end

            if (tick_c && enable) begin
                lfsr <= lfsr_next_c;
            end

            if (tick_c) begin
                pending <= 1'b1;
            end else if (pending) begin
                pending <= 1'b0;
            end

            sample_valid <= pending;
            if (pending) begin
                sample_out <= enable ? wave_c : MIDSCALE;
            end
        end
    end

endmodule
